// File: rtl/uart_tx_arbiter_if.sv
// Bus bundle between two byte requesters and the shared UART transmitter:
// per-requester valid/data/ready plus the serial line and status outputs.
interface uart_tx_arbiter_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_ready;
  logic       uart_tx;
  logic       busy;
  logic       grant;
  logic       frame_done;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, uart_tx, busy, grant, frame_done
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, uart_tx, busy, grant, frame_done
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding an 8N1 UART transmitter that
// sends one bit per clock, followed by GAP_BITS idle bit times per frame.
module uart_tx_arbiter #(
  parameter int unsigned GAP_BITS = 1
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam logic [3:0] GAP_LAST = (GAP_BITS == 0) ? 4'd0 : 4'(GAP_BITS - 1);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [3:0] r_gap_cnt;
  logic       r_ptr;
  logic       r_grant;
  logic       r_tx;
  logic       r_busy;
  logic       r_frame_done;
  logic       w_sel;
  logic       w_ready0;
  logic       w_ready1;
  logic       w_hs;
  logic       w_done;

  // Round-robin pick: the pointer only breaks ties, a lone requester always wins.
  always_comb begin
    w_sel = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      w_sel = r_ptr;
    end else if (bus.req1_valid) begin
      w_sel = 1'b1;
    end else begin
      w_sel = 1'b0;
    end
  end

  assign w_ready0 = (r_state == S_IDLE) && !reset && bus.req0_valid && !w_sel;
  assign w_ready1 = (r_state == S_IDLE) && !reset && bus.req1_valid &&  w_sel;
  assign w_hs     = w_ready0 || w_ready1;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; w_done marks the return to IDLE that ends a frame.
  always_comb begin
    w_next_state = r_state;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_next_state = S_START;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_START: begin
        w_next_state = S_DATA;
      end
      S_DATA: begin
        if (r_bit_cnt == 3'd7) begin
          w_next_state = S_STOP;
        end else begin
          w_next_state = S_DATA;
        end
      end
      S_STOP: begin
        if (GAP_BITS == 0) begin
          w_next_state = S_IDLE;
          w_done       = 1'b1;
        end else begin
          w_next_state = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_LAST) begin
          w_next_state = S_IDLE;
          w_done       = 1'b1;
        end else begin
          w_next_state = S_GAP;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Datapath: the line value registered here is what the state entered this edge emits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift      <= 8'd0;
      r_bit_cnt    <= 3'd0;
      r_gap_cnt    <= 4'd0;
      r_ptr        <= 1'b0;
      r_grant      <= 1'b0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_busy       <= (w_next_state != S_IDLE);
      r_frame_done <= w_done;
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_shift <= w_sel ? bus.req1_data : bus.req0_data;
            r_grant <= w_sel;
            r_ptr   <= ~w_sel;
            r_tx    <= 1'b0;
          end else begin
            r_tx    <= 1'b1;
          end
        end
        S_START: begin
          r_tx      <= r_shift[0];
          r_shift   <= {1'b0, r_shift[7:1]};
          r_bit_cnt <= 3'd0;
        end
        S_DATA: begin
          // Count k emits bit k+1; at count 7 the stop bit goes out and the counter wraps.
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            r_tx    <= 1'b1;
          end else begin
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
          end
        end
        S_STOP: begin
          r_tx      <= 1'b1;
          r_gap_cnt <= 4'd0;
        end
        S_GAP: begin
          r_tx <= 1'b1;
          if (r_gap_cnt == GAP_LAST) begin
            r_gap_cnt <= 4'd0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 4'd1;
          end
        end
        default: begin
          r_tx <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;
  assign bus.uart_tx    = r_tx;
  assign bus.busy       = r_busy;
  assign bus.grant      = r_grant;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a bit-queue line model checked every
// cycle, directed scenarios with literal expectations, and a randomized phase.
module tb_uart_tx_arbiter;
  localparam int GAP = 1;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  uart_tx_arbiter_if bus();
  uart_tx_arbiter_if bus_g0();

  uart_tx_arbiter #(.GAP_BITS(GAP)) dut    (.clk(clk), .reset(reset), .bus(bus));
  uart_tx_arbiter #(.GAP_BITS(0))   dut_g0 (.clk(clk), .reset(reset), .bus(bus_g0));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: the line is a queue of future bit values; busy means the queue was non-empty.
  bit m_busy, m_tx, m_fd, m_grant, m_ptr;
  bit m_q[$];

  always @(negedge clk) begin
    bit         v0, v1, sel, e0, e1;
    logic [7:0] d;
    if (reset) begin
      m_busy = 1'b0; m_tx = 1'b1; m_fd = 1'b0; m_grant = 1'b0; m_ptr = 1'b0;
      m_q.delete();
      chk("rst_ready0", bus.req0_ready, 1'b0);
      chk("rst_ready1", bus.req1_ready, 1'b0);
      chk("rst_tx",     bus.uart_tx,    1'b1);
      chk("rst_busy",   bus.busy,       1'b0);
      chk("rst_grant",  bus.grant,      1'b0);
      chk("rst_done",   bus.frame_done, 1'b0);
    end else begin
      v0  = bus.req0_valid;
      v1  = bus.req1_valid;
      sel = (v0 && v1) ? m_ptr : v1;
      e0  = !m_busy && v0 && !sel;
      e1  = !m_busy && v1 && sel;
      chk("m_ready0", bus.req0_ready, e0);
      chk("m_ready1", bus.req1_ready, e1);
      chk("m_tx",     bus.uart_tx,    m_tx);
      chk("m_busy",   bus.busy,       m_busy);
      chk("m_grant",  bus.grant,      m_grant);
      chk("m_done",   bus.frame_done, m_fd);
      if (e0 || e1) begin
        d       = sel ? bus.req1_data : bus.req0_data;
        m_grant = sel;
        m_ptr   = !sel;
        m_q.push_back(1'b0);
        for (int b = 0; b < 8; b++) m_q.push_back(d[b]);
        for (int g = 0; g <= GAP; g++) m_q.push_back(1'b1);
      end
      if (m_q.size() > 0) begin
        m_tx   = m_q.pop_front();
        m_busy = 1'b1;
        m_fd   = 1'b0;
      end else begin
        m_fd   = m_busy;
        m_busy = 1'b0;
        m_tx   = 1'b1;
      end
    end
  end

  task automatic wait_ready(input bit idx, output int c);
    c = -1;
    for (int k = 0; k < 40 && c < 0; k++) begin
      @(negedge clk);
      if ((idx ? bus.req1_ready : bus.req0_ready) === 1'b1) c = cyc;
    end
    chk("ready_seen", (c >= 0), 1'b1);
  endtask

  task automatic send(input bit idx, input logic [7:0] d, input bit hold, output int c);
    if (idx) begin bus.req1_valid = 1'b1; bus.req1_data = d; end
    else     begin bus.req0_valid = 1'b1; bus.req0_data = d; end
    wait_ready(idx, c);
    @(posedge clk); #1;
    if (!hold) begin
      if (idx) bus.req1_valid = 1'b0;
      else     bus.req0_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int k = 0; k < 40 && !idle; k++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) idle = 1'b1;
    end
    chk("idle_seen", idle, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    int         c0, c1, nh, nb, nf, nr;
    int         gidx[4];
    int         gcyc[4];
    logic [9:0] exp_a;
    logic [21:0] seq_g0;
    bit         drop;

    bus.req0_valid = 1'b0; bus.req0_data = 8'd0;
    bus.req1_valid = 1'b0; bus.req1_data = 8'd0;
    bus_g0.req0_valid = 1'b0; bus_g0.req0_data = 8'd0;
    bus_g0.req1_valid = 1'b0; bus_g0.req1_data = 8'd0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Single 0x48 from requester 0, valid already present at the first edge after release.
    bus.req0_valid = 1'b1; bus.req0_data = 8'h48; reset = 1'b0;
    send(1'b0, 8'h48, 1'b0, c0);
    exp_a = 10'b1010010000;
    nb = 0; nf = 0; nr = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i < 10) chk("a_tx_bit", bus.uart_tx, exp_a[i]);
      nb += int'(bus.busy);
      nf += int'(bus.frame_done);
      nr += int'(bus.req0_ready);
    end
    chk("a_busy_cycles", nb, 11);
    chk("a_done_pulses", nf, 1);
    chk("a_extra_ready", nr, 0);
    @(posedge clk); #1;

    // Contention from reset: both held valid, grants must alternate 12 cycles apart.
    reset = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_data = 8'h41;
    bus.req1_valid = 1'b1; bus.req1_data = 8'h42;
    @(posedge clk); #1 reset = 1'b0;
    nh = 0;
    for (int k = 0; k < 80 && nh < 4; k++) begin
      @(negedge clk);
      if (bus.req0_ready === 1'b1) begin gidx[nh] = 0; gcyc[nh] = cyc; nh++; end
      else if (bus.req1_ready === 1'b1) begin gidx[nh] = 1; gcyc[nh] = cyc; nh++; end
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    chk("b_handshakes", nh, 4);
    for (int i = 0; i < nh; i++) begin
      chk("b_grant_order", gidx[i], i % 2);
      if (i > 0) chk("b_spacing", gcyc[i] - gcyc[i-1], 12);
    end
    wait_idle();

    // Requester 1 alone, three bytes, no stall beyond the frame period.
    bus.req1_valid = 1'b1; bus.req1_data = 8'($urandom);
    nh = 0; nr = 0;
    for (int k = 0; k < 80 && nh < 3; k++) begin
      @(negedge clk);
      nr += int'(bus.req0_ready);
      if (bus.req1_ready === 1'b1) begin
        gcyc[nh] = cyc; nh++;
        @(posedge clk); #1;
        bus.req1_data = 8'($urandom);
        if (nh == 3) bus.req1_valid = 1'b0;
        @(negedge clk);
        chk("c_grant", bus.grant, 1'b1);
      end
    end
    chk("c_handshakes", nh, 3);
    chk("c_ready0_never", nr, 0);
    for (int i = 1; i < nh; i++) chk("c_spacing", gcyc[i] - gcyc[i-1], 12);
    wait_idle();

    // Valid dropped for the START cycle: frame unaffected, next handshake one period later.
    send(1'b0, 8'h5A, 1'b1, c0);
    bus.req0_valid = 1'b0;
    @(posedge clk); #1 bus.req0_valid = 1'b1;
    wait_ready(1'b0, c1);
    chk("d_spacing", c1 - c0, 12);
    @(posedge clk); #1 bus.req0_valid = 1'b0;
    wait_idle();

    // Reset in the middle of DATA: line returns high immediately and stays there.
    send(1'b0, 8'hA5, 1'b0, c0);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    chk("e_tx_async",   bus.uart_tx,    1'b1);
    chk("e_busy_async", bus.busy,       1'b0);
    chk("e_ready1_rst", bus.req1_ready, 1'b0);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0; reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("e_tx_after", bus.uart_tx,    1'b1);
      chk("e_no_done",  bus.frame_done, 1'b0);
    end
    @(posedge clk); #1;

    // Randomized traffic with occasional reset pulses; the model checks every cycle.
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 599) == 0) reset = 1'b1;
      bus.req0_valid = ($urandom_range(0, 2) == 0);
      bus.req1_valid = ($urandom_range(0, 2) == 0);
      bus.req0_data  = 8'($urandom);
      bus.req1_data  = 8'($urandom);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; reset = 1'b0;
    wait_idle();
    wait_idle();

    // GAP_BITS=0 instance: 0xFF then 0x00 back to back, 11-cycle period.
    bus_g0.req0_valid = 1'b1; bus_g0.req0_data = 8'hFF;
    bus_g0.req1_valid = 1'b1; bus_g0.req1_data = 8'h00;
    c0 = -1;
    for (int k = 0; k < 40 && c0 < 0; k++) begin
      @(negedge clk);
      if (bus_g0.req0_ready === 1'b1) c0 = cyc;
    end
    chk("g_first_seen", (c0 >= 0), 1'b1);
    @(posedge clk); #1 bus_g0.req0_valid = 1'b0;
    c1 = -1; drop = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      seq_g0[i] = bus_g0.uart_tx;
      if (bus_g0.req1_ready === 1'b1) begin c1 = cyc; drop = 1'b1; end
      @(posedge clk); #1;
      if (drop) bus_g0.req1_valid = 1'b0;
    end
    chk("g_period", c1 - c0, 11);
    for (int i = 0; i < 22; i++) begin
      chk("g_tx_bit", seq_g0[i], ((i == 0) || (i >= 11 && i <= 19)) ? 1'b0 : 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
